// File: rtl/inv_mix_columns.sv
// AES InvMixColumns engine: accepts one 128-bit state and transforms one column per cycle over four cycles.
// Optional macro INV_MIX_BYPASS_EN adds a bypass input that passes the state through unchanged.
`timescale 1ns/1ps
module inv_mix_columns (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef INV_MIX_BYPASS_EN
  input  logic         bypass,
`endif
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t         r_fsm;
  logic [1:0]   r_cnt;
  logic [127:0] r_state;
  logic [127:0] r_out;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;
  logic [127:0] w_state_nxt;
`ifdef INV_MIX_BYPASS_EN
  logic         r_bypass;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // 0x09, 0x0b, 0x0d and 0x0e all decompose into x8 plus a subset of {x4, x2, x1}.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    gmul = (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    inv_col[31:24] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    inv_col[23:16] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    inv_col[15:8]  = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    inv_col[7:0]   = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
  endfunction

  always_comb begin
    w_col_in    = r_state[127:96];
    w_state_nxt = r_state;
    case (r_cnt)
      2'd0:    w_col_in = r_state[127:96];
      2'd1:    w_col_in = r_state[95:64];
      2'd2:    w_col_in = r_state[63:32];
      default: w_col_in = r_state[31:0];
    endcase
`ifdef INV_MIX_BYPASS_EN
    w_col_out = r_bypass ? w_col_in : inv_col(w_col_in);
`else
    w_col_out = inv_col(w_col_in);
`endif
    case (r_cnt)
      2'd0:    w_state_nxt[127:96] = w_col_out;
      2'd1:    w_state_nxt[95:64]  = w_col_out;
      2'd2:    w_state_nxt[63:32]  = w_col_out;
      default: w_state_nxt[31:0]   = w_col_out;
    endcase
  end

  // Result is copied to r_out only when the last column lands, so a partial state is never driven out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_cnt       <= 2'd0;
      r_state     <= '0;
      r_out       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef INV_MIX_BYPASS_EN
      r_bypass    <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_state    <= state_in;
            r_cnt      <= 2'd0;
            r_fsm      <= BUSY;
            r_in_ready <= 1'b0;
`ifdef INV_MIX_BYPASS_EN
            r_bypass   <= bypass;
`endif
          end
        end
        BUSY: begin
          r_state <= w_state_nxt;
          if (r_cnt == 2'd3) begin
            r_fsm       <= DONE;
            r_out       <= w_state_nxt;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_fsm       <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign state_out = r_out;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Scoreboard bench for inv_mix_columns using directed vectors with known InvMixColumns results.
`timescale 1ns/1ps
module tb_inv_mix_columns;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
`ifdef INV_MIX_BYPASS_EN
  logic         bypass;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [127:0] sb[$];

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] V2_IN  = 128'hc6c6c6c6_01010101_4d7ebdf8_00000000;
  localparam logic [127:0] V2_OUT = 128'hc6c6c6c6_01010101_2d26314c_00000000;
  localparam logic [127:0] V3_IN  = 128'h01010101_d5d5d7d6_8e4da1bc_c6c6c6c6;
  localparam logic [127:0] V3_OUT = 128'h01010101_d4d4d4d5_db135345_c6c6c6c6;

  inv_mix_columns dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef INV_MIX_BYPASS_EN
    .bypass    (bypass),
`endif
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected result whenever an output handshake is about to occur.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", state_out, '0);
        if (state_out === '0) begin
          n_err++;
          $display("FAIL unexpected_output: got output with empty scoreboard, expected none");
        end
      end else begin
        chk("scoreboard_data", state_out, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after the acceptance edge, with in_valid dropped.
  task automatic send(input logic [127:0] d, input logic [127:0] exp);
    int n;
    n = 0;
    in_valid = 1'b1;
    state_in = d;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready_timeout", {127'd0, in_ready}, 128'd1);
    sb.push_back(exp);
    step();
    in_valid = 1'b0;
    state_in = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    chk("drain_timeout", 128'(sb.size()), 128'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
`ifdef INV_MIX_BYPASS_EN
    bypass    = 1'b0;
`endif
    step();
    step();
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_state_out", state_out, '0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Vector 1: latency exactly 4 edges after acceptance.
    send(V1_IN, V1_OUT);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("lat_out_valid_e%0d", k), {127'd0, out_valid}, (k == 4) ? 128'd1 : 128'd0);
      chk($sformatf("lat_in_ready_e%0d", k), {127'd0, in_ready}, 128'd0);
    end
    drain();
    chk("after_hs_in_ready", {127'd0, in_ready}, 128'd1);
    chk("after_hs_out_valid", {127'd0, out_valid}, 128'd0);

    // Vector 2: stall in DONE for 5 cycles while the input side is poked.
    send(V2_IN, V2_OUT);
    for (int k = 0; k < 4; k++) step();
    in_valid = 1'b1;
    state_in = V1_IN;
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", {127'd0, out_valid}, 128'd1);
      chk("stall_state_out", state_out, V2_OUT);
      chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
      step();
    end
    in_valid = 1'b0;
    drain();

    // Reset two cycles after acceptance discards the transaction.
    send(V1_IN, V1_OUT);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_state_out", state_out, '0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    sb.delete();
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    chk("midrst_release_in_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b0;
    send(V3_IN, V3_OUT);
    drain();

    // Back-to-back with in_valid held high and out_ready high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = V2_IN;
    sb.push_back(V2_OUT);
    step();
    state_in = V3_IN;
    for (int k = 1; k <= 4; k++) step();
    chk("b2b_out_valid_e4", {127'd0, out_valid}, 128'd1);
    step();
    chk("b2b_in_ready_e5", {127'd0, in_ready}, 128'd1);
    sb.push_back(V3_OUT);
    step();
    chk("b2b_accept_e6", {127'd0, in_ready}, 128'd0);
    in_valid = 1'b0;
    drain();

    // in_valid and data toggled while BUSY must not disturb the result.
    send(V2_IN, V2_OUT);
    for (int k = 0; k < 4; k++) begin
      in_valid = ~in_valid;
      state_in = (k % 2 == 0) ? V1_IN : V3_IN;
      step();
    end
    in_valid = 1'b0;
    chk("toggle_out_valid", {127'd0, out_valid}, 128'd1);
    drain();

`ifdef INV_MIX_BYPASS_EN
    bypass = 1'b1;
    send(128'h00112233_44556677_8899aabb_ccddeeff, 128'h00112233_44556677_8899aabb_ccddeeff);
    bypass = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk("bypass_out_valid", {127'd0, out_valid}, 128'd1);
    drain();
    send(V1_IN, V1_OUT);
    drain();
`endif

    step();
    chk("final_queue_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
